mips_alu_iter: RTL

//  Multi-cycle MIPS ALU. Consumes the 4-bit ALUCtrl code from the ALU control decoder and

---
 rtl/mips_alu_iter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mips_alu_iter.sv
// Multi-cycle MIPS ALU: single-cycle logic/arithmetic, bit-serial shifts,
// start/busy/done handshake with registered outputs held until the next done.
module mips_alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_SLLV = 4'b0011,
    OP_SRLV = 4'b0100, OP_SRAV = 4'b0101, OP_SUB  = 4'b0110, OP_SLT  = 4'b0111,
    OP_BNE  = 4'b1000, OP_SLL  = 4'b1001, OP_SRL  = 4'b1010, OP_XOR  = 4'b1011,
    OP_NOR  = 4'b1100, OP_SRA  = 4'b1101, OP_ILL  = 4'b1110, OP_SLTU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_e;

  state_e               state_q, state_d;
  alu_op_e              op_q, op_d, op_in;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]     sreg_q, sreg_d, sreg_step;
  logic [SHAMT_W-1:0]   count_q, count_d, amount_in;
  logic                 busy_d, done_d, zero_d, ovf_d, ill_d;
  logic [WIDTH-1:0]     result_d;
  logic [WIDTH-1:0]     sum, diff, exec_res;
  logic                 exec_ovf, in_is_shift;

  assign op_in = alu_op_e'(alu_ctrl);
  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;

  // Variable shifts take their amount from the low bits of rs instead of the shamt field.
  always_comb begin
    in_is_shift = 1'b0;
    amount_in   = shamt;
    case (op_in)
      OP_SLL, OP_SRL, OP_SRA:    in_is_shift = 1'b1;
      OP_SLLV, OP_SRLV, OP_SRAV: begin
        in_is_shift = 1'b1;
        amount_in   = a[SHAMT_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    case (op_q)
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOR:  exec_res = ~(a_q | b_q);
      OP_ADD: begin
        exec_res = sum;
        exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff;
        exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_BNE:  exec_res = diff;
      // Compare full operands, not the sign of the difference, so SLT cannot overflow.
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL, OP_SLLV: sreg_step = {sreg_q[WIDTH-2:0], 1'b0};
      OP_SRA, OP_SRAV: sreg_step = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      default:         sreg_step = {1'b0, sreg_q[WIDTH-1:1]};
    endcase
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sreg_d   = sreg_q;
    count_d  = count_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;
    zero_d   = zero;
    ovf_d    = overflow;
    ill_d    = illegal;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy) begin
          op_d    = op_in;
          a_d     = a;
          b_d     = b;
          sreg_d  = b;
          count_d = amount_in;
          busy_d  = 1'b1;
          state_d = in_is_shift ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = exec_res;
        zero_d   = (op_q == OP_BNE) ? (a_q != b_q) : (exec_res == '0);
        ovf_d    = exec_ovf;
        ill_d    = (op_q == OP_ILL);
      end
      S_SHIFT: begin
        if (count_q != '0) begin
          sreg_d  = sreg_step;
          count_d = count_q - SHAMT_W'(1);
        end else begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          result_d = sreg_q;
          zero_d   = (sreg_q == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      sreg_q   <= '0;
      count_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sreg_q   <= sreg_d;
      count_q  <= count_d;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
      zero     <= zero_d;
      overflow <= ovf_d;
      illegal  <= ill_d;
    end
  end

endmodule
